// File: rtl/innerproduct_seq_ctrl.sv
// Purpose: sequential inner product of N streamed unsigned features with N ROM coefficients, wrapping mod 2^TW.
// Latency: 2 cycles from the final feature accept to h_valid (one DRAIN cycle for the last product, then OUT).
// Backpressure: x_ready only in RUN (x_valid gaps stall idx); h_valid/hprime held stable in OUT until h_ready.
module innerproduct_seq_ctrl #(
    parameter int N  = 81,
    parameter int XW = 7,
    parameter int TW = 32,
    parameter int AW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    input  logic [XW-1:0] x_data,
    input  logic          x_valid,
    output logic          x_ready,
    output logic [AW-1:0] theta_addr,
    input  logic [TW-1:0] theta_data,
    output logic [TW-1:0] hprime,
    output logic          h_valid,
    input  logic          h_ready
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [TW-1:0] acc_q, acc_d;
    logic [XW-1:0] x_q, x_d;
    logic          pv_q, pv_d;

    // Handshake outputs are flops decoded from the next state.
    logic          x_ready_q;
    logic          busy_q;
    logic          h_valid_q;

    logic          accept;
    logic          last_idx;
    logic [TW-1:0] x_ext;
    logic [TW-1:0] prod;

    assign accept   = x_ready_q & x_valid;
    assign last_idx = (idx_q == AW'(N - 1));

    // theta_data arrives one cycle after the address, i.e. alongside x_q.
    assign x_ext = TW'(x_q);
    assign prod  = x_ext * theta_data;

    assign x_ready    = x_ready_q;
    assign busy       = busy_q;
    assign h_valid    = h_valid_q;
    assign hprime     = acc_q;
    assign theta_addr = idx_q;

    // Next-state logic: accept pipeline, pending accumulate and state transitions.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        x_d     = x_q;
        pv_d    = 1'b0;

        // A product registered last cycle is folded in now, whatever the state.
        if (pv_q) begin
            acc_d = acc_q + prod;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (accept) begin
                    x_d   = x_data;
                    pv_d  = 1'b1;
                    idx_d = idx_q + AW'(1);
                    if (last_idx) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                state_d = S_OUT;
            end
            S_OUT: begin
                if (h_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort drops any in-flight product and leaves acc/idx untouched.
        if (abort) begin
            state_d = S_IDLE;
            idx_d   = idx_q;
            acc_d   = acc_q;
            x_d     = x_q;
            pv_d    = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            acc_q     <= '0;
            x_q       <= '0;
            pv_q      <= 1'b0;
            x_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            h_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            x_q       <= x_d;
            pv_q      <= pv_d;
            x_ready_q <= (state_d == S_RUN);
            busy_q    <= (state_d != S_IDLE);
            h_valid_q <= (state_d == S_OUT);
        end
    end

endmodule

// File: tb/tb_innerproduct_seq_ctrl.sv
// Directed and randomized bench for innerproduct_seq_ctrl with a registered ROM model and
// an arithmetic reference (plain sum of products over the stimulus arrays).
module tb_innerproduct_seq_ctrl;

    localparam int N  = 81;
    localparam int XW = 7;
    localparam int TW = 32;
    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          busy;
    logic [XW-1:0] x_data;
    logic          x_valid;
    logic          x_ready;
    logic [AW-1:0] theta_addr;
    logic [TW-1:0] theta_data;
    logic [TW-1:0] hprime;
    logic          h_valid;
    logic          h_ready;

    logic [TW-1:0] rom [2**AW];
    logic [XW-1:0] xs  [N];

    int n_assert = 0;
    int n_fail   = 0;
    int op_acc   = 0;
    int addr_err = 0;
    int hs_cnt   = 0;
    int hv_cnt   = 0;

    innerproduct_seq_ctrl #(.N(N), .XW(XW), .TW(TW), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .busy       (busy),
        .x_data     (x_data),
        .x_valid    (x_valid),
        .x_ready    (x_ready),
        .theta_addr (theta_addr),
        .theta_data (theta_data),
        .hprime     (hprime),
        .h_valid    (h_valid),
        .h_ready    (h_ready)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data for an address appears one cycle later.
    always @(posedge clk) theta_data <= rom[theta_addr];

    // Observe handshakes mid-cycle, where inputs and registered outputs are settled.
    always @(negedge clk) begin
        if (x_valid && x_ready) begin
            if (int'(theta_addr) != op_acc) addr_err = addr_err + 1;
            op_acc = op_acc + 1;
        end
        if (h_valid && h_ready) hs_cnt = hs_cnt + 1;
        if (h_valid) hv_cnt = hv_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert = n_assert + 1;
        assert (obs === exp) else begin
            n_fail = n_fail + 1;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model();
        logic [31:0] acc = 32'd0;
        for (int i = 0; i < N; i++) acc = acc + 32'(xs[i]) * rom[i];
        return acc;
    endfunction

    // vmode: 0 = x_valid held high, 1 = toggling, 2 = random.
    task automatic stream(input int count, input int vmode, input bit start_noise);
        int i = 0;
        int budget = 0;
        bit v;
        bit rdy;
        bit ph = 1'b1;
        op_acc   = 0;
        addr_err = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("run_xready", 32'(x_ready), 32'd1);
        chk("run_busy", 32'(busy), 32'd1);
        chk("run_addr0", 32'(theta_addr), 32'd0);
        while (i < count && budget < 1000) begin
            case (vmode)
                0:       v = 1'b1;
                1:       begin v = ph; ph = ~ph; end
                default: v = 1'($urandom_range(1, 0));
            endcase
            x_valid = v;
            x_data  = v ? xs[i] : XW'($urandom);
            if (start_noise) start = 1'($urandom_range(1, 0));
            rdy = x_ready;
            tick();
            if (v && rdy) i++;
            budget++;
        end
        x_valid = 1'b0;
        start   = 1'b0;
        chk("stream_done", 32'(i), 32'(count));
    endtask

    // Entered right after the final accept edge, i.e. while in DRAIN.
    task automatic finish_op(input int hold, input logic [31:0] exp);
        int hs0 = hs_cnt;
        chk("lat_drain_hvalid", 32'(h_valid), 32'd0);
        chk("drain_xready", 32'(x_ready), 32'd0);
        tick();
        chk("lat_out_hvalid", 32'(h_valid), 32'd1);
        chk("hprime", hprime, exp);
        for (int k = 0; k < hold; k++) begin
            tick();
            chk("hold_hvalid", 32'(h_valid), 32'd1);
            chk("hold_hprime", hprime, exp);
        end
        h_ready = 1'b1;
        tick();
        h_ready = 1'b0;
        chk("done_hvalid", 32'(h_valid), 32'd0);
        chk("done_busy", 32'(busy), 32'd0);
        chk("accept_count", 32'(op_acc), 32'(N));
        chk("addr_errors", 32'(addr_err), 32'd0);
        chk("handshakes", 32'(hs_cnt - hs0), 32'd1);
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_xready"}, 32'(x_ready), 32'd0);
        chk({tag, "_hvalid"}, 32'(h_valid), 32'd0);
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 2**AW; i++) rom[i] = 32'(i);
        for (int i = 0; i < N; i++) xs[i] = XW'(1);
    endtask

    initial begin
        int hv0;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        x_data = '0; x_valid = 1'b0; h_ready = 1'b0;
        load_ramp();
        tick();
        tick();
        check_idle_zero("reset");
        chk("reset_hprime", hprime, 32'd0);
        chk("reset_addr", 32'(theta_addr), 32'd0);
        rst = 1'b0;
        tick();

        // Ramp coefficients, unit features, x_valid held high.
        stream(N, 0, 1'b0);
        finish_op(0, 32'd3240);

        // Saturated operands wrap modulo 2^32.
        for (int i = 0; i < 2**AW; i++) rom[i] = 32'hFFFF_FFFF;
        for (int i = 0; i < N; i++) xs[i] = XW'(127);
        stream(N, 0, 1'b0);
        finish_op(0, 32'd4294957009);

        // Toggling x_valid plus 5 cycles of output backpressure.
        load_ramp();
        stream(N, 1, 1'b0);
        finish_op(5, 32'd3240);

        // Reset after 40 accepts: everything cleared, no result produced.
        hv0 = hv_cnt;
        stream(40, 0, 1'b0);
        rst = 1'b1;
        tick();
        check_idle_zero("midrst");
        chk("midrst_hprime", hprime, 32'd0);
        chk("midrst_addr", 32'(theta_addr), 32'd0);
        rst = 1'b0;
        repeat (4) tick();
        chk("midrst_no_hvalid", 32'(hv_cnt - hv0), 32'd0);
        stream(N, 0, 1'b0);
        finish_op(1, 32'd3240);

        // Abort while draining the final product.
        hv0 = hv_cnt;
        stream(N, 0, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle_zero("abort_drain");
        repeat (4) tick();
        chk("abort_no_hvalid", 32'(hv_cnt - hv0), 32'd0);

        // Abort in the middle of RUN, then a clean operation with start noise in RUN.
        stream(30, 2, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle_zero("abort_run");
        tick();
        stream(N, 0, 1'b1);
        finish_op(2, 32'd3240);

        // Randomized operands and flow control against the arithmetic reference.
        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < 2**AW; i++) rom[i] = $urandom;
            for (int i = 0; i < N; i++) xs[i] = XW'($urandom);
            stream(N, 2, 1'b1);
            finish_op(int'($urandom_range(3, 0)), model());
            repeat (int'($urandom_range(2, 0))) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
